fir_sample_loader: RTL and testbench
====================================

Name: fir_sample_loader

Overview:
- Upstream feeder for fir_top: takes a valid/ready byte stream of input samples and writes it into port A of the shared 1024x8 sample memory.
- Once the buffer is loaded, it pulses start to the FIR and waits for done.
- It replaces direct memory forcing. Bench and system load data through a real write path and get load/run status flags.

Parameters:
- ADDR_W, 10, memory address width.
- DATA_W, 8, sample width.
- DEPTH, 1024, memory depth; max load length.
- DONE_TIMEOUT, 65535, cycles allowed in WAIT_DONE before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- go  in  1  arm a load/run; sampled only in IDLE
- load_len  in  ADDR_W+1  number of samples to load (1..DEPTH), latched on go
- s_valid  in  1  input sample valid
- s_ready  out  1  loader can accept sample
- s_data  in  DATA_W  sample value (two's complement)
- s_last  in  1  marks final sample of stream
- mem_addr_a  out  ADDR_W  memory port A address
- mem_we_a  out  1  memory port A write enable
- mem_data_in_a  out  DATA_W  memory port A write data
- fir_start  out  1  one-cycle start pulse to fir_top
- fir_done  in  1  done from fir_top
- busy  out  1  high in every state except IDLE
- run_done  out  1  one-cycle pulse on completion (normal or error)
- loaded_count  out  ADDR_W+1  samples accepted from stream in the last load
- err_len  out  1  sticky: load_len was 0 or greater than DEPTH
- err_short  out  1  sticky: s_last arrived before load_len samples
- err_no_last  out  1  sticky: final sample lacked s_last
- err_timeout  out  1  sticky: fir_done not seen within DONE_TIMEOUT

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation aborts immediately. Memory words already written are kept; no further writes occur.
- States: IDLE, LOAD, ZERO_FILL, KICK, WAIT_DONE, FINISH.
- IDLE, go=1:
  - All err_* flags clear.
  - load_len is latched.
  - If load_len is 0 or greater than DEPTH: set err_len and go to FINISH.
  - Otherwise go to LOAD.
- IDLE, go=0: nothing happens. go is ignored in all other states.
- LOAD:
  - s_ready=1 while write index < len.
  - Accepted beat (s_valid and s_ready) at cycle n drives mem_we_a=1, mem_addr_a=idx, mem_data_in_a=s_data at cycle n+1 (registered, 1-cycle latency).
  - idx and loaded_count increment per beat. Full throughput is one sample per cycle.
- Beat with idx = len-1:
  - If s_last=0, set err_no_last.
  - Next state is KICK.
  - s_ready drops the cycle after that beat; further stream beats are not accepted.
- Beat with s_last=1 and idx < len-1:
  - Set err_short; next state is ZERO_FILL.
- ZERO_FILL:
  - s_ready=0.
  - Writes 0 to addresses idx+1..len-1, one per cycle, with mem_we_a=1.
  - Then goes to KICK.
- KICK: fir_start=1 for exactly one cycle, mem_we_a=0, then WAIT_DONE.
- WAIT_DONE:
  - A cycle counter runs.
  - fir_done=1 goes to FINISH.
  - If the counter reaches DONE_TIMEOUT: set err_timeout and go to FINISH.
- FINISH: run_done=1 for one cycle, then IDLE.
- loaded_count and err_* hold until the next go or reset.
- mem_we_a is 0 outside the LOAD write cycle and ZERO_FILL. mem_addr_a holds its last value when idle.
- Addresses never wrap: idx stays below len, which is at most DEPTH.
- fir_done already high on entry to WAIT_DONE: accepted on the first WAIT_DONE cycle.

Decomposition:
- Shared package fir_pkg holds:
  - state encoding localparams;
  - ADDR_W/DATA_W/DEPTH defaults, shared with fir_top and the memory.
- No sub-module needed. The timeout counter is inline.

Test Plan:
- Nominal load: go with load_len=16; stream 16 beats 0x40,0x40,...,0x20 with s_last on beat 16.
  - Memory addresses 0..15 hold the data, 1 cycle after each accept.
  - One fir_start pulse; run_done follows fir_done.
  - loaded_count=16, all errors 0.
- Backpressure gaps: load_len=8, s_valid toggled 1010...
  - Exactly 8 writes at addresses 0..7 in order.
  - No writes during gaps; s_ready drops after beat 8.
- Short stream: load_len=10, s_last on beat 4.
  - Addresses 4..9 written with 0.
  - err_short=1, loaded_count=4, fir_start still pulses.
- Length errors:
  - load_len=0: err_len=1, run_done one cycle later, no memory writes, no fir_start.
  - load_len=1025: same response.
- Timeout: DONE_TIMEOUT=20, fir_done held 0.
  - err_timeout=1 and run_done exactly 20 cycles into WAIT_DONE.
- Reset mid-LOAD: assert rst after 3 of 8 beats.
  - Next cycle: all outputs 0, mem_we_a=0.
  - Addresses 0..2 retain their data.
  - A new go with load_len=4 completes normally.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR sample memory geometry and loader state encoding
package fir_pkg;
    localparam int FIR_ADDR_W       = 10;
    localparam int FIR_DATA_W       = 8;
    localparam int FIR_DEPTH        = 1024;
    localparam int FIR_DONE_TIMEOUT = 65535;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ZERO_FILL,
        S_KICK,
        S_WAIT_DONE,
        S_FINISH
    } loader_state_e;
endpackage

// File: rtl/fir_sample_loader_if.sv
// fir_sample_loader_if: valid/ready sample stream feeding the loader
interface fir_sample_loader_if #(parameter int DATA_W = fir_pkg::FIR_DATA_W);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/fir_sample_loader.sv
// fir_sample_loader: streams samples into FIR memory port A, kicks the FIR and reports status
module fir_sample_loader
    import fir_pkg::*;
#(
    parameter int ADDR_W       = FIR_ADDR_W,
    parameter int DATA_W       = FIR_DATA_W,
    parameter int DEPTH        = FIR_DEPTH,
    parameter int DONE_TIMEOUT = FIR_DONE_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W:0]   load_len,
    fir_sample_loader_if.slave s,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic              mem_we_a,
    output logic [DATA_W-1:0] mem_data_in_a,
    output logic              fir_start,
    input  logic              fir_done,
    output logic              busy,
    output logic              run_done,
    output logic [ADDR_W:0]   loaded_count,
    output logic              err_len,
    output logic              err_short,
    output logic              err_no_last,
    output logic              err_timeout
);
    localparam int LW = ADDR_W + 1;
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);
    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, idx_q, idx_d, cnt_q, cnt_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic [3:0]        err_q, err_d;
    logic              acc, at_end, bad_len;
    assign bad_len       = load_len == '0 || load_len > DEPTH_L;
    assign s.s_ready     = state_q == S_LOAD && idx_q < len_q;
    assign acc           = s.s_valid && s.s_ready;
    assign at_end        = idx_q == len_q - 1'b1;
    assign mem_addr_a    = addr_q;
    assign mem_we_a      = we_q;
    assign mem_data_in_a = data_q;
    assign fir_start     = state_q == S_KICK;
    assign busy          = state_q != S_IDLE;
    assign run_done      = state_q == S_FINISH;
    assign loaded_count  = cnt_q;
    // error flags packed as {timeout, no_last, short, len}
    assign {err_timeout, err_no_last, err_short, err_len} = err_q;
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (go) begin
                len_d   = load_len;
                idx_d   = '0;
                cnt_d   = '0;
                err_d   = {3'b000, bad_len};
                state_d = bad_len ? S_FINISH : S_LOAD;
            end
            S_LOAD: if (acc) begin
                we_d   = 1'b1;
                addr_d = idx_q[ADDR_W-1:0];
                data_d = s.s_data;
                idx_d  = idx_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (at_end) begin
                    err_d[2] = !s.s_last;
                    state_d  = S_KICK;
                end else if (s.s_last) begin
                    err_d[1] = 1'b1;
                    state_d  = S_ZERO_FILL;
                end
            end
            S_ZERO_FILL: begin
                we_d    = 1'b1;
                addr_d  = idx_q[ADDR_W-1:0];
                data_d  = '0;
                idx_d   = idx_q + 1'b1;
                state_d = at_end ? S_KICK : S_ZERO_FILL;
            end
            S_KICK: begin
                tmr_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                tmr_d    = tmr_q + 1'b1;
                err_d[3] = !fir_done && tmr_q == TMO_LAST;
                state_d  = (fir_done || tmr_q == TMO_LAST) ? S_FINISH : S_WAIT_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_fir_sample_loader.sv
// tb_fir_sample_loader: randomized stream loads checked against a queue-based reference model
module tb_fir_sample_loader;
    localparam int TMO = 20;
    logic        clk = 1'b0, rst = 1'b1, go = 1'b0, fir_done = 1'b0;
    logic [10:0] load_len = '0;
    logic [9:0]  mem_addr_a;
    logic        mem_we_a;
    logic [7:0]  mem_data_in_a;
    logic        fir_start, busy, run_done;
    logic [10:0] loaded_count;
    logic        err_len, err_short, err_no_last, err_timeout;
    fir_sample_loader_if #(.DATA_W(8)) sif ();
    fir_sample_loader #(.DONE_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .go(go), .load_len(load_len), .s(sif),
        .mem_addr_a(mem_addr_a), .mem_we_a(mem_we_a), .mem_data_in_a(mem_data_in_a),
        .fir_start(fir_start), .fir_done(fir_done), .busy(busy), .run_done(run_done),
        .loaded_count(loaded_count), .err_len(err_len), .err_short(err_short),
        .err_no_last(err_no_last), .err_timeout(err_timeout)
    );
    always #5 clk = ~clk;
    int n_checks = 0, n_errors = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    // passive monitor: memory image, write log, pulse counters, write latency
    logic [7:0]  mem [1024];
    logic [17:0] wr_q[$];
    int          cyc = 0, n_start = 0, n_done = 0, start_cyc = 0, done_cyc = 0, go_cyc = 0;
    logic        acc_p = 1'b0;
    logic [7:0]  acc_data_p = '0;
    always @(negedge clk) begin
        cyc++;
        if (acc_p) check("wr_latency", 64'({mem_we_a, mem_data_in_a}), 64'({1'b1, acc_data_p}));
        acc_p      = sif.s_valid && sif.s_ready && !rst;
        acc_data_p = sif.s_data;
        if (go && !busy) go_cyc = cyc;
        if (fir_start) begin n_start++; start_cyc = cyc; end
        if (run_done) begin n_done++; done_cyc = cyc; end
        if (mem_we_a) begin
            mem[mem_addr_a] = mem_data_in_a;
            wr_q.push_back({mem_addr_a, mem_data_in_a});
        end
    end
    // FIR stand-in: answers fir_start after a random delay unless a timeout is being exercised
    bit tmo_mode = 1'b0;
    int exp_lat  = 0;
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (fir_start && !tmo_mode) begin
                d       = $urandom_range(0, 4);
                exp_lat = (d == 0) ? 2 : d + 1;
                repeat (d) @(negedge clk);
                fir_done = 1'b1;
                for (int t = 0; t < 50 && !run_done; t++) @(negedge clk);
                fir_done = 1'b0;
            end
        end
    end
    // reference model: beats to send and the writes/flags they must produce
    logic [7:0]  bd[$];
    bit          bl[$];
    logic [17:0] exp_wr[$];
    int          e_cnt;
    bit          e_len, e_short, e_nolast;
    task automatic build(input int nb, input int last_at, input bit nominal);
        bd.delete();
        bl.delete();
        for (int i = 0; i < nb; i++) begin
            bd.push_back(nominal ? ((i == nb - 1) ? 8'h20 : 8'h40) : 8'($urandom));
            bl.push_back(i == last_at);
        end
    endtask
    task automatic predict(input int len);
        exp_wr.delete();
        e_cnt    = 0;
        e_len    = len == 0 || len > 1024;
        e_short  = 1'b0;
        e_nolast = 1'b0;
        if (!e_len) begin
            for (int i = 0; i < len; i++) begin
                exp_wr.push_back({10'(i), bd[i]});
                e_cnt++;
                if (i == len - 1) e_nolast = !bl[i];
                else if (bl[i]) begin
                    e_short = 1'b1;
                    for (int j = i + 1; j < len; j++) exp_wr.push_back({10'(j), 8'h00});
                    break;
                end
            end
        end
    endtask
    task automatic send(input int gap);
        for (int i = 0; i < bd.size(); i++) begin
            sif.s_valid = 1'b0;
            repeat ((gap < 0) ? $urandom_range(0, 2) : gap) begin @(posedge clk); #1; end
            sif.s_valid = 1'b1;
            sif.s_data  = bd[i];
            sif.s_last  = bl[i];
            for (int t = 0; ; t++) begin
                @(negedge clk);
                if (sif.s_ready) break;
                if (n_start > 0 || n_done > 0 || t > 200) begin
                    if (t > 200) check("send_stall", 64'(t), 64'(0));
                    sif.s_valid = 1'b0;
                    sif.s_last  = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask
    task automatic run_case(input string nm, input int len, input int nb, input int last_at,
                            input bit nominal, input int gap, input bit tmo);
        build(nb, last_at, nominal);
        predict(len);
        tmo_mode = tmo;
        n_start  = 0;
        n_done   = 0;
        wr_q.delete();
        go       = 1'b1;
        load_len = 11'(len);
        @(posedge clk); #1;
        go = 1'b0;
        if (!e_len) send(gap);
        for (int t = 0; t < 400 && n_done == 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check({nm, "/run_done"}, 64'(n_done), 64'(1));
        check({nm, "/fir_start"}, 64'(n_start), 64'(e_len ? 0 : 1));
        check({nm, "/loaded_count"}, 64'(loaded_count), 64'(e_cnt));
        check({nm, "/errors"}, 64'({err_len, err_short, err_no_last, err_timeout}),
              64'({e_len, e_short, e_nolast, tmo && !e_len}));
        check({nm, "/busy"}, 64'(busy), 64'(0));
        check({nm, "/n_writes"}, 64'(wr_q.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
            check({nm, "/write"}, 64'(wr_q[i]), 64'(exp_wr[i]));
        if (e_len) check({nm, "/done_lat"}, 64'(done_cyc - go_cyc), 64'(1));
        else check({nm, "/done_lat"}, 64'(done_cyc - start_cyc), 64'(tmo ? TMO + 1 : exp_lat));
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int len, m, k;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({busy, run_done, fir_start, mem_we_a, sif.s_ready, mem_addr_a,
              mem_data_in_a, loaded_count, err_len, err_short, err_no_last, err_timeout}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        run_case("nominal", 16, 16, 15, 1'b1, 0, 1'b0);
        run_case("backpressure", 8, 10, 7, 1'b0, 1, 1'b0);
        run_case("short", 10, 4, 3, 1'b0, 0, 1'b0);
        run_case("len0", 0, 0, -1, 1'b0, 0, 1'b0);
        run_case("len1025", 1025, 0, -1, 1'b0, 0, 1'b0);
        run_case("timeout", 5, 5, 4, 1'b0, 0, 1'b1);
        run_case("no_last", 6, 9, -1, 1'b0, 0, 1'b0);
        run_case("len1", 1, 1, 0, 1'b0, 0, 1'b0);
        run_case("depth", 1024, 1024, 1023, 1'b0, 0, 1'b0);
        // reset in the middle of a load after three beats
        build(8, 7, 1'b0);
        go       = 1'b1;
        load_len = 11'd8;
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = bd[i];
            sif.s_last  = 1'b0;
            @(posedge clk); #1;
        end
        sif.s_valid = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_outputs", 64'({busy, run_done, fir_start, mem_we_a, sif.s_ready, mem_addr_a,
              mem_data_in_a, loaded_count, err_len, err_short, err_no_last, err_timeout}), 64'(0));
        for (int i = 0; i < 3; i++) check("rst_mem_kept", 64'(mem[i]), 64'(bd[i]));
        @(posedge clk); #1;
        rst = 1'b0;
        run_case("after_reset", 4, 4, 3, 1'b0, 0, 1'b0);
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(1, 40);
            m   = $urandom_range(0, 3);
            if (m == 1 && len > 1) begin
                k = $urandom_range(0, len - 2);
                run_case("rand_short", len, k + 1, k, 1'b0, -1, $urandom_range(0, 5) == 0);
            end else if (m == 2) run_case("rand_nolast", len, len + 2, -1, 1'b0, -1, 1'b0);
            else if (m == 3) run_case("rand_latelast", len, len + 2, len + 1, 1'b0, -1, 1'b0);
            else run_case("rand_full", len, len, len - 1, 1'b0, -1, $urandom_range(0, 5) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
